fp_div_scheduler: RTL and testbench

Shares one combinational FP32 divider (the team's `divide` datapath, instantiated inside this block) among NUM_REQ requesters, using round-robin arbitration.
- Operands are registered at the divider input.
- The divider is given a DIV_LATENCY-cycle multicycle budget.
- The result is registered and returned on a single valid/ready response channel, tagged with the requester index.
- Sits between the TPU vector lanes and the divide unit, so the lanes need no per-lane dividers.

---
 rtl/fp_div_scheduler_pkg.sv | 22 ++
 rtl/fp_div_scheduler_if.sv | 37 +++
 rtl/fp_div_scheduler_divide.sv | 63 ++++++
 rtl/fp_div_scheduler_rr_arbiter.sv | 43 ++++
 rtl/fp_div_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fp_div_scheduler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fp_div_scheduler_pkg.sv
// fp_div_sched_pkg: shared types and constants for the FP32 divide scheduler.
// Contents:
//   state_e        scheduler FSM states (IDLE, COMPUTE, RESPOND)
//   FP32_QNAN      canonical quiet NaN returned for NaN operands
//   FP32_EXP_MAX   all-ones FP32 exponent (infinity / NaN)
//   quotientSign   sign bit of a/b
package fp_div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESPOND
  } state_e;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  function automatic logic quotientSign(input logic [31:0] a, input logic [31:0] b);
    return a[31] ^ b[31];
  endfunction

endpackage

// File: rtl/fp_div_scheduler_if.sv
// fp_div_scheduler_if: request/response bundle between the vector lanes and
// the shared divide scheduler.
// Signals:
//   reqValid/reqReady  per-requester operand handshake (reqReady one-hot or zero)
//   reqA/reqB          per-requester FP32 dividend/divisor
//   respValid/respReady single response handshake
//   respData/respId    FP32 quotient and index of the issuing requester
//   respDivByZero      divisor-zero flag
//   busy               scheduler is not idle
// Modports: master = requesters/consumer side, slave = scheduler side.
interface fp_div_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ-1:0]       reqReady;
  logic [NUM_REQ-1:0][31:0] reqA;
  logic [NUM_REQ-1:0][31:0] reqB;
  logic                     respValid;
  logic                     respReady;
  logic [31:0]              respData;
  logic [ID_W-1:0]          respId;
  logic                     respDivByZero;
  logic                     busy;

  modport master (
    output reqValid, reqA, reqB, respReady,
    input  reqReady, respValid, respData, respId, respDivByZero, busy
  );

  modport slave (
    input  reqValid, reqA, reqB, respReady,
    output reqReady, respValid, respData, respId, respDivByZero, busy
  );

endinterface

// File: rtl/fp_div_scheduler_divide.sv
// divide: combinational FP32 divider for normal operands with round to
// nearest even. Results that overflow saturate to infinity, underflows flush
// to signed zero, and any operand with the maximum exponent yields a quiet NaN.
// Ports:
//   a  FP32 dividend
//   b  FP32 divisor
//   q  FP32 quotient
module divide
  import fp_div_sched_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  logic [49:0]        num;
  logic [49:0]        den;
  logic [26:0]        quo;
  logic [23:0]        rem;
  logic [23:0]        mant;
  logic               guard;
  logic               sticky;
  logic [24:0]        rounded;
  logic [22:0]        frac;
  logic signed [10:0] expAdj;
  logic signed [10:0] expFinal;
  logic               sign;

  // The 26 extra dividend bits leave a 24-bit mantissa plus guard and sticky
  // in the quotient whichever of the two mantissas is larger.
  always_comb begin
    sign   = quotientSign(a, b);
    num    = {1'b1, a[22:0], 26'b0};
    den    = {26'b0, 1'b1, b[22:0]};
    quo    = 27'(num / den);
    rem    = 24'(num % den);
    expAdj = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]});
    if (quo[26]) begin
      mant   = quo[26:3];
      guard  = quo[2];
      sticky = (|quo[1:0]) | (|rem);
      expAdj = expAdj + 11'sd127;
    end else begin
      mant   = quo[25:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
      expAdj = expAdj + 11'sd126;
    end
    rounded  = {1'b0, mant} + {24'b0, guard & (sticky | mant[0])};
    expFinal = rounded[24] ? expAdj + 11'sd1 : expAdj;
    frac     = rounded[24] ? rounded[23:1] : rounded[22:0];
    if (a[30:23] == FP32_EXP_MAX || b[30:23] == FP32_EXP_MAX) begin
      q = FP32_QNAN;
    end else if (expFinal >= 11'sd255) begin
      q = {sign, FP32_EXP_MAX, 23'b0};
    end else if (expFinal <= 11'sd0) begin
      q = {sign, 31'b0};
    end else begin
      q = {sign, expFinal[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_div_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. The search starts at rrPtr
// and wraps modulo NUM_REQ; the pointer itself lives in the scheduler.
// Ports:
//   req       request vector
//   rrPtr     highest-priority requester index
//   enable    gates all grants
//   grant     one-hot grant (zero when disabled or nothing requested)
//   grantIdx  index of the granted requester
//   anyReq    a grant was issued
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rrPtr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grantIdx,
  output logic               anyReq
);

  // Walk the requesters in priority order; the first valid one wins.
  always_comb begin
    int sum;
    logic [ID_W-1:0] idx;
    sum      = 0;
    idx      = '0;
    grant    = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(rrPtr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (enable && !anyReq && req[idx]) begin
        anyReq     = 1'b1;
        grant[idx] = 1'b1;
        grantIdx   = idx;
      end
    end
  end

endmodule

// File: rtl/fp_div_scheduler.sv
// fp_div_scheduler: shares one combinational FP32 divider among NUM_REQ
// requesters using round-robin arbitration. Operands are registered in front
// of the divider, which gets DIV_LATENCY cycles to settle before the result is
// captured and returned on a single tagged valid/ready response channel.
// Optional build macro: FP_DIV_SPECIAL_EN enables NaN / zero / infinity
// operand overrides and the respDivByZero flag; without it respDivByZero is 0.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    fp_div_scheduler_if.slave (request, response and busy signals)
module fp_div_scheduler
  import fp_div_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  fp_div_scheduler_if.slave  bus
);

  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  state_e              state;
  state_e              nextState;
  logic [ID_W-1:0]     rrPtr;
  logic [ID_W-1:0]     rrPtrNext;
  logic [ID_W-1:0]     idReg;
  logic [ID_W-1:0]     grantIdx;
  logic [CNT_W-1:0]    count;
  logic [31:0]         opA;
  logic [31:0]         opB;
  logic [31:0]         divResult;
  logic [NUM_REQ-1:0]  grant;
  logic                anyReq;
  logic                arbEnable;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .req      (bus.reqValid),
    .rrPtr    (rrPtr),
    .enable   (arbEnable),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyReq   (anyReq)
  );

  divide u_divide (
    .a (opA),
    .b (opB),
    .q (divResult)
  );

  // Priority moves to the requester just after the one being served.
  assign rrPtrNext = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);

`ifdef FP_DIV_SPECIAL_EN
  logic        specialHit;
  logic        specialDbz;
  logic [31:0] specialData;

  // Special operands are decoded from the registered operands; the first
  // matching rule wins.
  always_comb begin
    logic sign;
    sign        = quotientSign(opA, opB);
    specialHit  = 1'b0;
    specialDbz  = 1'b0;
    specialData = '0;
    if ((opA[30:23] == FP32_EXP_MAX && opA[22:0] != '0) ||
        (opB[30:23] == FP32_EXP_MAX && opB[22:0] != '0)) begin
      specialHit  = 1'b1;
      specialData = FP32_QNAN;
    end else if (opB[30:23] == '0) begin
      specialHit  = 1'b1;
      specialDbz  = 1'b1;
      specialData = {sign, FP32_EXP_MAX, 23'b0};
    end else if (opA[30:23] == '0) begin
      specialHit  = 1'b1;
      specialData = {sign, 31'b0};
    end else if (opA[30:23] == FP32_EXP_MAX) begin
      specialHit  = 1'b1;
      specialData = {sign, FP32_EXP_MAX, 23'b0};
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: a grant is only possible in IDLE, and the response
  // must be consumed before the next grant.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = COMPUTE;
      COMPUTE: if (count == '0) nextState = RESPOND;
      RESPOND: if (bus.respReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic decoded from the current state.
  always_comb begin
    arbEnable     = (state == IDLE);
    bus.reqReady  = grant;
    bus.respValid = (state == RESPOND);
    bus.busy      = (state != IDLE);
  end

  // Datapath: operand capture on grant, settle countdown, result capture.
  // Response registers are only written on the COMPUTE->RESPOND edge, so they
  // stay stable while RESPOND waits for respReady.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr             <= '0;
      count             <= '0;
      opA               <= '0;
      opB               <= '0;
      idReg             <= '0;
      bus.respData      <= '0;
      bus.respId        <= '0;
      bus.respDivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            opA   <= bus.reqA[grantIdx];
            opB   <= bus.reqB[grantIdx];
            idReg <= grantIdx;
            rrPtr <= rrPtrNext;
            count <= CNT_W'(DIV_LATENCY - 1);
          end
        end
        COMPUTE: begin
          if (count == '0) begin
            bus.respId <= idReg;
`ifdef FP_DIV_SPECIAL_EN
            bus.respData      <= specialHit ? specialData : divResult;
            bus.respDivByZero <= specialDbz;
`else
            bus.respData      <= divResult;
            bus.respDivByZero <= 1'b0;
`endif
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_scheduler.sv
// tb_fp_div_scheduler: self-checking bench for fp_div_scheduler. Expected
// grants come from a round-robin search over an integer pointer, expected
// quotients from real-valued division rounded back to FP32.
module tb_fp_div_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int DIV_LATENCY = 2;
  localparam int ID_W        = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rrModel     = 0;

  always #5 clk = ~clk;

  fp_div_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  fp_div_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .DIV_LATENCY (DIV_LATENCY),
    .ID_W        (ID_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Widen an FP32 pattern to a double pattern (normal operands only).
  function automatic logic [63:0] toDouble(input logic [31:0] f);
    logic [10:0] e;
    e = {3'b000, f[30:23]} + 11'd896;
    return {f[31], e, f[22:0], 29'b0};
  endfunction

  // Quotient in double precision, then rounded to nearest even FP32.
  function automatic logic [31:0] refDiv(input logic [31:0] a, input logic [31:0] b);
    real         ra, rb;
    logic [63:0] d;
    logic [10:0] e;
    logic [30:0] mag;
    ra  = $bitstoreal(toDouble(a));
    rb  = $bitstoreal(toDouble(b));
    d   = $realtobits(ra / rb);
    e   = d[62:52] - 11'd896;
    mag = {e[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  function automatic int expectGrant(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] oneHot(input int g);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] randFloat();
    logic [7:0] e;
    e = 8'($urandom_range(144, 110));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Waits for respValid (sampled at negedges) with a cycle budget; cycles is
  // -1 when the budget expires. readyBusy counts cycles with any reqReady set.
  task automatic waitResponse(output logic [31:0] data, output logic [ID_W-1:0] id,
                              output logic dbz, output int cycles, output int readyBusy);
    cycles    = 0;
    readyBusy = 0;
    while (cycles < 50) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus.reqReady !== '0) readyBusy++;
      if (bus.respValid === 1'b1) break;
    end
    if (bus.respValid !== 1'b1) cycles = -1;
    data = bus.respData;
    id   = bus.respId;
    dbz  = bus.respDivByZero;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    bus.reqValid  = '0;
    bus.reqA      = '0;
    bus.reqB      = '0;
    bus.respReady = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.respValid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_respValid: got %b expected 0", bus.respValid);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
    vectors++;
    if (bus.respData !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_respData: got %h expected 0", bus.respData);
    end
    vectors++;
    if (bus.respId !== '0) begin
      miscompares++; $display("[TB] FAIL reset_respId: got %0d expected 0", bus.respId);
    end
    vectors++;
    if (bus.respDivByZero !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_divByZero: got %b expected 0", bus.respDivByZero);
    end
    reset = 1'b0;
    rrModel = 0;
    @(negedge clk);
    vectors++;
    if (bus.reqReady !== '0 || bus.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_after_reset: reqReady %b busy %b expected 0000 0", bus.reqReady, bus.busy);
    end
  endtask

  task automatic test_single;
    logic [31:0] d, expQ;
    logic [ID_W-1:0] id;
    logic z;
    int cyc, rb;
    bus.reqA[0]   = 32'h40C0_0000;
    bus.reqB[0]   = 32'h4000_0000;
    bus.reqValid  = 4'b0001;
    bus.respReady = 1'b1;
    expQ = refDiv(bus.reqA[0], bus.reqB[0]);
    #1;
    vectors++;
    if (bus.reqReady !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL single_grant: got %b expected 0001", bus.reqReady);
    end
    @(posedge clk);
    rrModel = 1;
    @(negedge clk);
    bus.reqValid = '0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.reqReady !== '0) begin
      miscompares++; $display("[TB] FAIL single_compute: busy %b reqReady %b expected 1 0000", bus.busy, bus.reqReady);
    end
    waitResponse(d, id, z, cyc, rb);
    vectors++;
    if (cyc !== DIV_LATENCY) begin
      miscompares++; $display("[TB] FAIL single_latency: got %0d expected %0d", cyc, DIV_LATENCY);
    end
    vectors++;
    if (d !== expQ || d !== 32'h4040_0000) begin
      miscompares++; $display("[TB] FAIL single_data: got %h expected 40400000", d);
    end
    vectors++;
    if (id !== 2'd0 || z !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_tag: id %0d dbz %b expected 0 0", id, z);
    end
    @(negedge clk);
    vectors++;
    if (bus.respValid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_release: respValid %b busy %b expected 0 0", bus.respValid, bus.busy);
    end
  endtask

  task automatic test_two_same_cycle;
    logic [31:0] d, expQ;
    logic [31:0] constQ [2] = '{32'hC040_0000, 32'h3E80_0000};
    int constId [2] = '{1, 2};
    logic [ID_W-1:0] id;
    logic z;
    int cyc, rb, g;
    bus.reqA[2]  = 32'h3F80_0000;
    bus.reqB[2]  = 32'h4080_0000;
    bus.reqA[1]  = 32'hC110_0000;
    bus.reqB[1]  = 32'h4040_0000;
    bus.reqValid = 4'b0110;
    for (int n = 0; n < 2; n++) begin
      #1;
      g = expectGrant(bus.reqValid, rrModel);
      expQ = refDiv(bus.reqA[g], bus.reqB[g]);
      vectors++;
      if (bus.reqReady !== oneHot(g)) begin
        miscompares++; $display("[TB] FAIL pair_grant%0d: got %b expected %b", n, bus.reqReady, oneHot(g));
      end
      @(posedge clk);
      rrModel = (g + 1) % NUM_REQ;
      @(negedge clk);
      bus.reqValid[g] = 1'b0;
      waitResponse(d, id, z, cyc, rb);
      vectors++;
      if (d !== expQ || d !== constQ[n]) begin
        miscompares++; $display("[TB] FAIL pair_data%0d: got %h expected %h", n, d, constQ[n]);
      end
      vectors++;
      if (int'(id) !== constId[n] || cyc < 0) begin
        miscompares++; $display("[TB] FAIL pair_id%0d: got %0d (cycles %0d) expected %0d", n, id, cyc, constId[n]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, expQ;
    logic [ID_W-1:0] id;
    logic z;
    int cyc, rb, g;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rrModel = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.reqA[r] = randFloat();
      bus.reqB[r] = randFloat();
    end
    bus.reqValid  = '1;
    bus.respReady = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      g = expectGrant(bus.reqValid, rrModel);
      expQ = refDiv(bus.reqA[g], bus.reqB[g]);
      vectors++;
      if (bus.reqReady !== oneHot(g) || g !== (n % NUM_REQ)) begin
        miscompares++; $display("[TB] FAIL b2b_grant%0d: got %b expected %b", n, bus.reqReady, oneHot(n % NUM_REQ));
      end
      @(posedge clk);
      rrModel = (g + 1) % NUM_REQ;
      @(negedge clk);
      bus.reqA[g] = randFloat();
      bus.reqB[g] = randFloat();
      vectors++;
      if (bus.reqReady !== '0) begin
        miscompares++; $display("[TB] FAIL b2b_ready_in_compute%0d: got %b expected 0000", n, bus.reqReady);
      end
      waitResponse(d, id, z, cyc, rb);
      vectors++;
      if (d !== expQ) begin
        miscompares++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", n, d, expQ);
      end
      vectors++;
      if (int'(id) !== g || z !== 1'b0 || cyc !== DIV_LATENCY || rb !== 0) begin
        miscompares++; $display("[TB] FAIL b2b_resp%0d: id %0d dbz %b cycles %0d readyBusy %0d expected %0d 0 %0d 0",
                                n, id, z, cyc, rb, g, DIV_LATENCY);
      end
      @(negedge clk);
    end
    bus.reqValid = '0;
  endtask

  task automatic test_hold;
    logic [31:0] d, d0, expQ;
    logic [ID_W-1:0] id, id0;
    logic z;
    int cyc, rb, g;
    bus.respReady = 1'b0;
    bus.reqA[1]   = randFloat();
    bus.reqB[1]   = randFloat();
    bus.reqA[3]   = randFloat();
    bus.reqB[3]   = randFloat();
    bus.reqValid  = 4'b1010;
    #1;
    g = expectGrant(bus.reqValid, rrModel);
    expQ = refDiv(bus.reqA[g], bus.reqB[g]);
    vectors++;
    if (bus.reqReady !== oneHot(g)) begin
      miscompares++; $display("[TB] FAIL hold_grant: got %b expected %b", bus.reqReady, oneHot(g));
    end
    @(posedge clk);
    rrModel = (g + 1) % NUM_REQ;
    @(negedge clk);
    bus.reqValid[g] = 1'b0;
    waitResponse(d0, id0, z, cyc, rb);
    vectors++;
    if (d0 !== expQ || int'(id0) !== g || cyc < 0) begin
      miscompares++; $display("[TB] FAIL hold_first: data %h id %0d expected %h %0d", d0, id0, expQ, g);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.respValid !== 1'b1 || bus.respData !== d0 || bus.respId !== id0 ||
          bus.reqReady !== '0 || bus.busy !== 1'b1) begin
        miscompares++; $display("[TB] FAIL hold_stall%0d: valid %b data %h id %0d reqReady %b busy %b expected 1 %h %0d 0000 1",
                                k, bus.respValid, bus.respData, bus.respId, bus.reqReady, bus.busy, d0, id0);
      end
    end
    bus.respReady = 1'b1;
    @(negedge clk);
    #1;
    g = expectGrant(bus.reqValid, rrModel);
    expQ = refDiv(bus.reqA[g], bus.reqB[g]);
    vectors++;
    if (bus.respValid !== 1'b0 || bus.reqReady !== oneHot(g)) begin
      miscompares++; $display("[TB] FAIL hold_resume: valid %b reqReady %b expected 0 %b", bus.respValid, bus.reqReady, oneHot(g));
    end
    @(posedge clk);
    rrModel = (g + 1) % NUM_REQ;
    @(negedge clk);
    bus.reqValid = '0;
    waitResponse(d, id, z, cyc, rb);
    vectors++;
    if (d !== expQ || int'(id) !== g || cyc < 0) begin
      miscompares++; $display("[TB] FAIL hold_second: data %h id %0d expected %h %0d", d, id, expQ, g);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, expQ;
    logic [ID_W-1:0] id;
    logic z;
    int cyc, rb, g, seen;
    bus.respReady = 1'b1;
    bus.reqA[2]   = randFloat();
    bus.reqB[2]   = randFloat();
    bus.reqValid  = 4'b0100;
    #1;
    g = expectGrant(bus.reqValid, rrModel);
    vectors++;
    if (bus.reqReady !== oneHot(g)) begin
      miscompares++; $display("[TB] FAIL rmid_grant: got %b expected %b", bus.reqReady, oneHot(g));
    end
    @(posedge clk);
    @(negedge clk);
    bus.reqValid = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.respValid !== 1'b0 || bus.busy !== 1'b0 || bus.respData !== 32'h0 ||
        bus.respId !== '0 || bus.reqReady !== '0) begin
      miscompares++; $display("[TB] FAIL rmid_outputs: valid %b busy %b data %h id %0d reqReady %b expected all 0",
                              bus.respValid, bus.busy, bus.respData, bus.respId, bus.reqReady);
    end
    @(negedge clk);
    reset = 1'b0;
    rrModel = 0;
    seen = 0;
    for (int k = 0; k < DIV_LATENCY + 4; k++) begin
      @(negedge clk);
      if (bus.respValid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("[TB] FAIL rmid_no_response: got %0d valid cycles expected 0", seen);
    end
    bus.reqA[0]  = randFloat();
    bus.reqB[0]  = randFloat();
    bus.reqA[3]  = randFloat();
    bus.reqB[3]  = randFloat();
    bus.reqValid = 4'b1001;
    #1;
    g = expectGrant(bus.reqValid, rrModel);
    expQ = refDiv(bus.reqA[g], bus.reqB[g]);
    vectors++;
    if (bus.reqReady !== oneHot(g) || g !== 0) begin
      miscompares++; $display("[TB] FAIL rmid_regrant: got %b expected 0001", bus.reqReady);
    end
    @(posedge clk);
    rrModel = (g + 1) % NUM_REQ;
    @(negedge clk);
    bus.reqValid = '0;
    waitResponse(d, id, z, cyc, rb);
    vectors++;
    if (d !== expQ || int'(id) !== g || cyc !== DIV_LATENCY) begin
      miscompares++; $display("[TB] FAIL rmid_after: data %h id %0d cycles %0d expected %h %0d %0d", d, id, cyc, expQ, g, DIV_LATENCY);
    end
    @(negedge clk);
  endtask

`ifdef FP_DIV_SPECIAL_EN
  task automatic test_special;
    logic [31:0] sa [2] = '{32'h3F80_0000, 32'h7FC0_0001};
    logic [31:0] sb [2] = '{32'h0000_0000, 32'h4000_0000};
    logic [31:0] sq [2] = '{32'h7F80_0000, 32'h7FC0_0000};
    logic        sz [2] = '{1'b1, 1'b0};
    logic [31:0] d;
    logic [ID_W-1:0] id;
    logic z;
    int cyc, rb, g;
    bus.respReady = 1'b1;
    for (int n = 0; n < 2; n++) begin
      bus.reqA[0]  = sa[n];
      bus.reqB[0]  = sb[n];
      bus.reqValid = 4'b0001;
      #1;
      g = expectGrant(bus.reqValid, rrModel);
      @(posedge clk);
      rrModel = (g + 1) % NUM_REQ;
      @(negedge clk);
      bus.reqValid = '0;
      waitResponse(d, id, z, cyc, rb);
      vectors++;
      if (d !== sq[n] || z !== sz[n] || cyc < 0) begin
        miscompares++; $display("[TB] FAIL special%0d: data %h dbz %b expected %h %b", n, d, z, sq[n], sz[n]);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two_same_cycle();
    test_back_to_back();
    test_hold();
    test_reset_mid();
`ifdef FP_DIV_SPECIAL_EN
    test_special();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
